// File: rtl/l15_scratchpad_responder_pkg.sv
// Shared types for the L1.5 scratchpad responder.
// Request kinds, FSM states and the default-width request/return bundles.
package l15_scratchpad_responder_pkg;

  typedef enum logic [1:0] {
    L15_LOAD  = 2'd0,
    L15_STORE = 2'd1,
    L15_IFILL = 2'd2,
    L15_RSVD  = 2'd3
  } l15_scratch_req_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } l15_scratch_state_e;

  localparam int unsigned L15_ADDR_W = 64;
  localparam int unsigned L15_DATA_W = 64;
  localparam int unsigned L15_LINE_W = 128;
  localparam int unsigned L15_TID_W  = 2;

  typedef struct packed {
    l15_scratch_req_e        rtype;
    logic [L15_TID_W-1:0]    tid;
    logic [L15_ADDR_W-1:0]   paddr;
    logic [L15_DATA_W-1:0]   wdata;
    logic [L15_DATA_W/8-1:0] be;
  } l15_scratch_req_t;

  typedef struct packed {
    l15_scratch_req_e      rtype;
    logic [L15_TID_W-1:0]  tid;
    logic [L15_LINE_W-1:0] data;
    logic                  err;
  } l15_scratch_rtrn_t;

endpackage

// File: rtl/l15_scratchpad_responder_sram.sv
// Single-port word SRAM: 1-cycle read latency, byte-enabled write.
// Technology cut point; read data holds until the next read.
module scratch_sram #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Words     = 8192,
  parameter int unsigned AddrBits  = 13
) (
  input  logic                   clk_i,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [AddrBits-1:0]    addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic [DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] r_mem [Words];
  logic [DataWidth-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < DataWidth/8; i++) begin
          if (be_i[i]) r_mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[addr_i];
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/l15_scratchpad_responder.sv
// Memory-side responder for the write-through L1.5 NoC interface.
// Serves load/store/ifill from a local SRAM, one request in flight.
module l15_scratchpad_responder
  import l15_scratchpad_responder_pkg::*;
#(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          LineWidth = 128,
  parameter int unsigned          TidWidth  = 2,
  parameter int unsigned          MemBytes  = 65536,
  parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(64'h8000_0000),
  parameter bit                   BigEndian = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_type_i,
  input  logic [TidWidth-1:0]    req_tid_i,
  input  logic [AddrWidth-1:0]   req_paddr_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  output logic                   rtrn_valid_o,
  input  logic                   rtrn_ready_i,
  output logic [1:0]             rtrn_type_o,
  output logic [TidWidth-1:0]    rtrn_tid_o,
  output logic [LineWidth-1:0]   rtrn_data_o,
  output logic                   rtrn_err_o
);

  localparam int unsigned NB    = LineWidth / DataWidth;
  localparam int unsigned BPW   = DataWidth / 8;
  localparam int unsigned WORDS = MemBytes / BPW;
  localparam int unsigned WAW   = $clog2(WORDS);
  localparam int unsigned BOW   = $clog2(BPW);
  localparam int unsigned OFW   = WAW + BOW;
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned AW1   = AddrWidth + 1;
  localparam logic [AddrWidth:0] LIMIT =
    {1'b0, BaseAddr} + AW1'(MemBytes);

  function automatic logic [DataWidth-1:0] f_swap(
    input logic [DataWidth-1:0] d
  );
    logic [DataWidth-1:0] s;
    for (int i = 0; i < BPW; i++) s[i*8 +: 8] = d[(BPW-1-i)*8 +: 8];
    return s;
  endfunction

  function automatic logic [BPW-1:0] f_swap_be(input logic [BPW-1:0] b);
    logic [BPW-1:0] s;
    for (int i = 0; i < BPW; i++) s[i] = b[BPW-1-i];
    return s;
  endfunction

  function automatic logic [WAW-1:0] f_line(input logic [WAW-1:0] w);
    return w & ~WAW'(NB - 1);
  endfunction

  l15_scratch_state_e r_state, w_state_nxt;
  l15_scratch_req_e   r_type, w_type;

  logic                 r_init;
  logic [TidWidth-1:0]  r_tid;
  logic [WAW-1:0]       r_word;
  logic [DataWidth-1:0] r_wdata;
  logic [BPW-1:0]       r_be;
  logic                 r_err;
  logic [BW-1:0]        r_beat;
  logic                 r_pend;
  logic [BW-1:0]        r_cap;
  logic [DataWidth-1:0] r_line [NB];

  logic                 w_hs;
  logic                 w_err;
  logic [OFW-1:0]       w_off;
  logic [WAW-1:0]       w_word;
  logic                 w_sram_en;
  logic                 w_sram_we;
  logic [WAW-1:0]       w_sram_addr;
  logic [DataWidth-1:0] w_rdata;

  assign w_type = l15_scratch_req_e'(req_type_i);
  assign w_hs   = req_valid_i & req_ready_o;
  assign w_off  = OFW'(req_paddr_i - BaseAddr);
  assign w_word = WAW'(w_off >> BOW);
  assign w_err  = (req_paddr_i < BaseAddr)
               || ({1'b0, req_paddr_i} >= LIMIT)
               || (w_type == L15_RSVD);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (w_err)                   w_state_nxt = S_RESP;
          else if (w_type == L15_STORE) w_state_nxt = S_WRITE;
          else                         w_state_nxt = S_READ;
        end
      end
      S_READ:  if (r_beat == BW'(NB - 1)) w_state_nxt = S_RESP;
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  if (rtrn_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_init  <= 1'b0;
      r_type  <= L15_LOAD;
      r_tid   <= '0;
      r_word  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_err   <= 1'b0;
      r_beat  <= '0;
      r_pend  <= 1'b0;
      r_cap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= 1'b1;
      r_pend  <= (r_state == S_READ);
      r_cap   <= r_beat;
      r_beat  <= (r_state == S_READ) ? r_beat + 1'b1 : '0;
      if (w_hs) begin
        r_type  <= w_type;
        r_tid   <= req_tid_i;
        r_err   <= w_err;
        r_word  <= (w_type == L15_STORE) ? w_word : f_line(w_word);
        // One swap on the write path stores the big-endian image;
        // reads return that image as-is.
        r_wdata <= BigEndian ? f_swap(req_wdata_i) : req_wdata_i;
        r_be    <= BigEndian ? f_swap_be(req_be_i) : req_be_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_pend) r_line[r_cap] <= w_rdata;
  end

  assign w_sram_en   = (r_state == S_READ) || (r_state == S_WRITE);
  assign w_sram_we   = (r_state == S_WRITE);
  assign w_sram_addr = (r_state == S_READ) ? r_word + WAW'(r_beat) : r_word;

  scratch_sram #(
    .DataWidth (DataWidth),
    .Words     (WORDS),
    .AddrBits  (WAW)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (w_sram_en),
    .we_i    (w_sram_we),
    .addr_i  (w_sram_addr),
    .wdata_i (r_wdata),
    .be_i    (r_be),
    .rdata_o (w_rdata)
  );

  // The last beat is still in the SRAM output register on RESP entry.
  always_comb begin
    rtrn_data_o = '0;
    if (r_state == S_RESP && !r_err && r_type != L15_STORE) begin
      for (int k = 0; k < NB; k++) begin
        rtrn_data_o[k*DataWidth +: DataWidth] =
          (r_pend && r_cap == BW'(k)) ? w_rdata : r_line[k];
      end
    end
  end

  assign req_ready_o  = r_init && (r_state == S_IDLE);
  assign rtrn_valid_o = (r_state == S_RESP);
  assign rtrn_type_o  = r_type;
  assign rtrn_tid_o   = r_tid;
  assign rtrn_err_o   = r_err;

endmodule

// File: tb/tb_l15_scratchpad_responder.sv
// Scoreboard bench for l15_scratchpad_responder.
// Expected returns are queued at request accept and popped at return.
module tb_l15_scratchpad_responder;

  localparam int unsigned NW = 8192;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [1:0]   req_type_i = '0;
  logic [1:0]   req_tid_i = '0;
  logic [63:0]  req_paddr_i = '0;
  logic [63:0]  req_wdata_i = '0;
  logic [7:0]   req_be_i = '0;
  logic         rtrn_valid_o;
  logic         rtrn_ready_i = 1'b1;
  logic [1:0]   rtrn_type_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] rtrn_data_o;
  logic         rtrn_err_o;

  l15_scratchpad_responder dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_type_i   (req_type_i),
    .req_tid_i    (req_tid_i),
    .req_paddr_i  (req_paddr_i),
    .req_wdata_i  (req_wdata_i),
    .req_be_i     (req_be_i),
    .rtrn_valid_o (rtrn_valid_o),
    .rtrn_ready_i (rtrn_ready_i),
    .rtrn_type_o  (rtrn_type_o),
    .rtrn_tid_o   (rtrn_tid_o),
    .rtrn_data_o  (rtrn_data_o),
    .rtrn_err_o   (rtrn_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   t;
    logic [1:0]   tid;
    logic [127:0] d;
    logic         e;
    int unsigned  hs;
    int unsigned  lat;
  } exp_t;

  exp_t        q[$];
  exp_t        em;
  logic [63:0] mem [NW];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          seen = 0;
  bit          rnd_ready = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_ready) rtrn_ready_i = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      seen = 0;
    end else if (rtrn_valid_o) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rtrn tid=%0d cyc=%0d", rtrn_tid_o, cyc);
      end else begin
        if (!seen) begin
          seen = 1;
          checks++;
          if (cyc - q[0].hs !== q[0].lat) begin
            errors++;
            $display("FAIL latency tid=%0d got %0d exp %0d",
                     rtrn_tid_o, cyc - q[0].hs, q[0].lat);
          end
        end
        if (rtrn_ready_i) begin
          em = q.pop_front();
          seen = 0;
          checks++;
          if ({rtrn_type_o, rtrn_tid_o, rtrn_err_o, rtrn_data_o}
              !== {em.t, em.tid, em.e, em.d}) begin
            errors++;
            $display("FAIL rtrn got t=%0d tid=%0d e=%0b d=%h exp t=%0d tid=%0d e=%0b d=%h",
                     rtrn_type_o, rtrn_tid_o, rtrn_err_o, rtrn_data_o,
                     em.t, em.tid, em.e, em.d);
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] t, input logic [1:0] tid,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic [7:0] be, output int unsigned hs);
    exp_t        e;
    bit          ok;
    bit          inr;
    int unsigned lw;
    int unsigned w;
    @(posedge clk); #1;
    req_valid_i = 1; req_type_i = t; req_tid_i = tid;
    req_paddr_i = a; req_wdata_i = wd; req_be_i = be;
    ok = 0;
    hs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_timeout tid=%0d addr=%h", tid, a);
    end else begin
      hs = cyc;
      inr = ({1'b0, a} >= {1'b0, BASE}) &&
            ({1'b0, a} < ({1'b0, BASE} + 65'h1_0000));
      e.t = t; e.tid = tid; e.hs = cyc; e.d = '0;
      e.e = !inr || (t == 2'd3);
      if (e.e) e.lat = 1;
      else if (t == 2'd1) e.lat = 2;
      else e.lat = 3;
      if (!e.e) begin
        w = int'((a - BASE) >> 3);
        lw = w & ~32'd1;
        if (t == 2'd1) begin
          for (int i = 0; i < 8; i++)
            if (be[i]) mem[w][(7-i)*8 +: 8] = wd[i*8 +: 8];
        end else begin
          e.d = {mem[lw+1], mem[lw]};
        end
      end
      q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid_i = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_ni = 0;
    rtrn_ready_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready_o, rtrn_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL in_reset ready=%0b valid=%0b exp 0 0", req_ready_o, rtrn_valid_o);
    end
    @(posedge clk); #1;
    rst_ni = 1;
    @(negedge clk);
    checks++;
    if ({req_ready_o, rtrn_valid_o, rtrn_type_o, rtrn_tid_o,
         rtrn_err_o, rtrn_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_cycle0 ready=%0b valid=%0b t=%0d tid=%0d e=%0b d=%h exp all 0",
               req_ready_o, rtrn_valid_o, rtrn_type_o, rtrn_tid_o,
               rtrn_err_o, rtrn_data_o);
    end
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_cycle1 ready=%0b exp 1", req_ready_o);
    end
  endtask

  task automatic test_fill();
    int unsigned hs;
    logic [31:0] w32;
    for (int w = 0; w < NW; w++) begin
      w32 = 32'(w);
      send(2'd1, w32[1:0], BASE + 64'(w) * 8,
           {w32 * 32'h9E37_79B9, w32 ^ 32'h5A5A_C3C3}, 8'hFF, hs);
    end
    wait_drain();
  endtask

  task automatic test_store_load();
    int unsigned hs;
    send(2'd1, 2'd1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, hs);
    send(2'd0, 2'd2, 64'h8000_0004, '0, '0, hs);
    wait_drain();
    checks++;
    if (mem[1] !== 64'h8877_6655_4433_2211) begin
      errors++;
      $display("FAIL model_word1 got %h exp 8877665544332211", mem[1]);
    end
  endtask

  task automatic test_byte_enable();
    int unsigned hs;
    send(2'd1, 2'd0, 64'h8000_0010, 64'hAA, 8'h01, hs);
    send(2'd0, 2'd3, 64'h8000_0010, '0, '0, hs);
    send(2'd1, 2'd1, 64'h8000_0028, 64'hDEAD_BEEF_0000_0000, 8'hF0, hs);
    send(2'd2, 2'd2, 64'h8000_0020, '0, '0, hs);
    wait_drain();
  endtask

  task automatic test_errors();
    int unsigned hs;
    send(2'd2, 2'd3, 64'h7FFF_FFF0, '0, '0, hs);
    send(2'd0, 2'd1, 64'h8001_0000, '0, '0, hs);
    send(2'd1, 2'd2, 64'h8001_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, hs);
    send(2'd1, 2'd0, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, hs);
    send(2'd3, 2'd1, 64'h8000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, hs);
    send(2'd0, 2'd2, 64'hFFFF_FFFF_FFFF_FFF8, '0, '0, hs);
    send(2'd0, 2'd3, 64'h8000_FFF8, '0, '0, hs);
    wait_drain();
    for (int l = 0; l < NW / 2; l++) begin
      send(2'd2, 2'(l), BASE + 64'(l) * 16, '0, '0, hs);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int unsigned hs;
    int unsigned r;
    bit          ok;
    logic [132:0] snap;
    @(posedge clk); #1;
    rtrn_ready_i = 0;
    send(2'd2, 2'd1, BASE + 64'h40, '0, '0, hs);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rtrn_valid_o === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid_timeout got 0 exp 1");
    end
    snap = {rtrn_type_o, rtrn_tid_o, rtrn_err_o, rtrn_data_o};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rtrn_valid_o, req_ready_o} !== 2'b10 ||
          {rtrn_type_o, rtrn_tid_o, rtrn_err_o, rtrn_data_o} !== snap) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d valid=%0b ready=%0b d=%h exp valid=1 ready=0 d=%h",
                 i, rtrn_valid_o, req_ready_o, rtrn_data_o, snap[127:0]);
      end
    end
    @(posedge clk); #1;
    rtrn_ready_i = 1;
    r = cyc;
    send(2'd0, 2'd2, BASE + 64'h80, '0, '0, hs);
    checks++;
    if (hs - r !== 1) begin
      errors++;
      $display("FAIL bp_accept_gap got %0d exp 1", hs - r);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int unsigned hs;
    bit          bad;
    send(2'd0, 2'd2, BASE + 64'h100, '0, '0, hs);
    @(posedge clk); #1;
    rst_ni = 0;
    if (q.size() != 0) void'(q.pop_back());
    @(posedge clk); #1;
    rst_ni = 1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rtrn_valid_o !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_reset_rtrn got valid=1 exp 0");
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready got %0b exp 1", req_ready_o);
    end
    send(2'd0, 2'd3, BASE + 64'h100, '0, '0, hs);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int unsigned hs;
    logic [1:0]  t;
    rnd_ready = 1;
    for (int i = 0; i < 80; i++) begin
      t = 2'($urandom_range(0, 2));
      send(t, 2'(i), BASE + (64'($urandom_range(0, 63)) << 3),
           {$urandom, $urandom}, 8'($urandom_range(0, 255)), hs);
    end
    rnd_ready = 0;
    @(posedge clk); #2;
    rtrn_ready_i = 1;
    wait_drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
